// File: rtl/shared_mem_responder_pkg.sv
// Shared encodings for the shared-memory responder: enable ops, default sizes,
// FSM state codes and a small index-width helper.
package shared_mem_responder_pkg;

  localparam int ENABLE_SIZE = 2;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_IDLE  = 2'b00;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_READ  = 2'b01;
  localparam logic [ENABLE_SIZE-1:0] ENABLE_WRITE = 2'b10;

  localparam int REG_SIZE_DEF     = 8;
  localparam int CORE_ID_SIZE_DEF = 4;
  localparam int ADDR_SIZE_DEF    = CORE_ID_SIZE_DEF + REG_SIZE_DEF;
  localparam int LAT_W            = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, in
// modular order; the pointer register lives in the parent.
module shared_mem_responder_rr_arbiter
  import shared_mem_responder_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = j;
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared data memory serving CORE_COUNT cores, one transaction at a time,
// round-robin. Define SHMEM_CLEAR_ON_RESET_EN to zero the memory after reset.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter int CORE_COUNT     = 4,
  parameter int REG_SIZE       = REG_SIZE_DEF,
  parameter int CORE_ID_SIZE   = CORE_ID_SIZE_DEF,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [ENABLE_SIZE*CORE_COUNT-1:0]          enable_M,
  input  logic [(CORE_ID_SIZE+REG_SIZE)*CORE_COUNT-1:0] addr_M,
  input  logic [REG_SIZE*CORE_COUNT-1:0]             wr_data_M,
  output logic [REG_SIZE*CORE_COUNT-1:0]             rd_data_M,
  output logic [CORE_COUNT-1:0]                      ready_M
);

  localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;
  localparam int MEM_DEPTH = 1 << ADDR_SIZE;
  localparam int IDX_W     = idx_width(CORE_COUNT);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ACCESS_LATENCY - 1);

  typedef struct packed {
    logic                  wr;
    logic [IDX_W-1:0]      core;
    logic [CORE_COUNT-1:0] oh;
    logic [ADDR_SIZE-1:0]  addr;
    logic [REG_SIZE-1:0]   wdata;
  } xact_t;

  logic [CORE_COUNT-1:0][ENABLE_SIZE-1:0] en;
  logic [CORE_COUNT-1:0][ADDR_SIZE-1:0]   addr;
  logic [CORE_COUNT-1:0][REG_SIZE-1:0]    wdata;
  logic [CORE_COUNT-1:0]                  req;

  assign en    = enable_M;
  assign addr  = addr_M;
  assign wdata = wr_data_M;

  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_req
    assign req[i] = |en[i];
  end

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  xact_t                 cur_q, cur_d;
  logic [CORE_COUNT-1:0] ready_q, ready_d;
  logic [CORE_COUNT-1:0][REG_SIZE-1:0] rd_q;
  logic                  rsp_enter;

  logic [CORE_COUNT-1:0] gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;

  logic [REG_SIZE-1:0]   mem_q [MEM_DEPTH];
  logic [REG_SIZE-1:0]   mem_rdata;
  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_wa;
  logic [REG_SIZE-1:0]   mem_wd;

`ifdef SHMEM_CLEAR_ON_RESET_EN
  logic [ADDR_SIZE-1:0]  clr_q, clr_d;
`endif

  shared_mem_responder_rr_arbiter #(
    .N     (CORE_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
`ifdef SHMEM_CLEAR_ON_RESET_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      ST_IDLE: if (gnt_any) begin
        // 2'b11 is not a write, so it falls through to a plain read
        cur_d.wr    = (en[gnt_idx] == ENABLE_WRITE);
        cur_d.core  = gnt_idx;
        cur_d.oh    = gnt_oh;
        cur_d.addr  = addr[gnt_idx];
        cur_d.wdata = wdata[gnt_idx];
        ptr_d       = (gnt_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : gnt_idx + 1'b1;
        cnt_d       = LAT_LOAD;
        state_d     = (ACCESS_LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
`ifdef SHMEM_CLEAR_ON_RESET_EN
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
    endcase
  end

  // Outputs are registered: load them on the edge that enters RESP.
  assign rsp_enter = (state_q != ST_RESP) && (state_d == ST_RESP);
  assign ready_d   = rsp_enter ? cur_d.oh : '0;
  assign mem_rdata = mem_q[cur_d.addr];

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SHMEM_CLEAR_ON_RESET_EN
      state_q <= ST_CLEAR;
      clr_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      ptr_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      ready_q <= '0;
      rd_q    <= '0;
    end else begin
`ifdef SHMEM_CLEAR_ON_RESET_EN
      clr_q   <= clr_d;
`endif
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      ready_q <= ready_d;
      if (rsp_enter && !cur_d.wr) rd_q[cur_d.core] <= mem_rdata;
    end
  end

  always_comb begin
    mem_we = !reset && (state_q == ST_RESP) && cur_q.wr;
    mem_wa = cur_q.addr;
    mem_wd = cur_q.wdata;
`ifdef SHMEM_CLEAR_ON_RESET_EN
    if (!reset && state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_q;
      mem_wd = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign rd_data_M = rd_q;
  assign ready_M   = ready_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Bench for shared_mem_responder: directed scenarios plus random traffic checked
// against a transaction-level model (server free time, rr pointer, memory map).
module tb_shared_mem_responder;

`ifdef SHMEM_CLEAR_ON_RESET_EN
  localparam int CID = 1, RSZ = 4;
  localparam bit CLR = 1'b1;
`else
  localparam int CID = 4, RSZ = 8;
  localparam bit CLR = 1'b0;
`endif
  localparam int N = 4, L = 2;
  localparam int ASZ = CID + RSZ, DEPTH = 1 << ASZ;
  localparam int BOUND = N * (L + 1) + L + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [2*N-1:0]     enable_M;
  logic [ASZ*N-1:0]   addr_M;
  logic [RSZ*N-1:0]   wr_data_M;
  logic [RSZ*N-1:0]   rd_data_M;
  logic [N-1:0]       ready_M;

  always #5 clk = ~clk;

  shared_mem_responder #(
    .CORE_COUNT(N), .REG_SIZE(RSZ), .CORE_ID_SIZE(CID), .ACCESS_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .enable_M(enable_M), .addr_M(addr_M),
    .wr_data_M(wr_data_M), .rd_data_M(rd_data_M), .ready_M(ready_M)
  );

  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // requesters
  logic [1:0]     rq_en   [N];
  logic [ASZ-1:0] rq_addr [N];
  logic [RSZ-1:0] rq_wd   [N];
  bit             rq_sticky [N];
  bit             rdy_seen  [N];
  int             age       [N];

  // reference model
  int             ptr_m, free_at, idle_from;
  bit             tx_v;
  int             tx_core, tx_due;
  logic [1:0]     tx_en;
  logic [ASZ-1:0] tx_addr;
  logic [RSZ-1:0] tx_wd;
  logic [RSZ-1:0] mem_m [int];
  logic [RSZ-1:0] rd_m [N];
  bit             rd_known [N];
  int             done_core[$], done_cyc[$];
  logic [ASZ-1:0] pool [8];

  task automatic step(input bit rst, input bit rnd);
    logic [N-1:0] exp_rdy;
    int j;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_seen[i] && !rq_sticky[i]) begin rq_en[i] = 2'b00; age[i] = 0; end
      if (rnd && rq_en[i] == 2'b00 && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    rq_en[i] = 2'b01;
          2, 3:    rq_en[i] = 2'b10;
          default: rq_en[i] = 2'b11;
        endcase
        rq_addr[i] = pool[$urandom_range(0, 7)];
        rq_wd[i]   = RSZ'($urandom);
      end
      enable_M[2*i +: 2]      = rq_en[i];
      addr_M[ASZ*i +: ASZ]    = rq_addr[i];
      wr_data_M[RSZ*i +: RSZ] = rq_wd[i];
    end
    reset   = rst;
    exp_rdy = '0;
    if (rst) begin
      tx_v      = 1'b0;
      ptr_m     = 0;
      free_at   = cyc + 1 + (CLR ? DEPTH : 0);
      idle_from = free_at;
      for (int i = 0; i < N; i++) begin rd_m[i] = '0; rd_known[i] = 1'b1; age[i] = 0; end
      if (CLR) mem_m.delete();
    end else begin
      if (!tx_v && cyc >= free_at) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (!tx_v && rq_en[j] != 2'b00) begin
            tx_v = 1'b1; tx_core = j; tx_en = rq_en[j];
            tx_addr = rq_addr[j]; tx_wd = rq_wd[j];
            tx_due = cyc + L; ptr_m = (j + 1) % N;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (rq_en[i] == 2'b00) age[i] = 0;
        else if (cyc >= idle_from) age[i]++;
      if (tx_v && tx_due == cyc) begin
        exp_rdy[tx_core] = 1'b1;
        if (tx_en != 2'b10) begin
          if (mem_m.exists(int'(tx_addr))) begin
            rd_m[tx_core] = mem_m[int'(tx_addr)]; rd_known[tx_core] = 1'b1;
          end else if (CLR) begin
            rd_m[tx_core] = '0; rd_known[tx_core] = 1'b1;
          end else rd_known[tx_core] = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (!rst) begin
      chk("ready", 32'(ready_M), 32'(exp_rdy));
      for (int i = 0; i < N; i++)
        if (rd_known[i]) chk($sformatf("rd_data%0d", i), 32'(rd_data_M[RSZ*i +: RSZ]), 32'(rd_m[i]));
      if (exp_rdy != '0) begin
        chk("starve", 32'(age[tx_core] <= BOUND), 32'd1);
        if (tx_en == 2'b10) mem_m[int'(tx_addr)] = tx_wd;
        done_core.push_back(tx_core);
        done_cyc.push_back(cyc);
        tx_v = 1'b0; free_at = cyc + 1; age[tx_core] = 0;
      end
    end
    for (int i = 0; i < N; i++) rdy_seen[i] = !rst && ready_M[i];
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin rq_en[i] = 2'b00; rq_sticky[i] = 1'b0; end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  // Hold one request until its ready pulse; lat counts from the first cycle it is driven.
  task automatic xact(input int c, input logic [1:0] en, input logic [ASZ-1:0] a,
                      input logic [RSZ-1:0] d, output int lat);
    int start;
    bit got;
    got = 1'b0; lat = -1;
    rdy_seen[c] = 1'b0;
    rq_en[c] = en; rq_addr[c] = a; rq_wd[c] = d;
    start = cyc + 1;
    for (int n = 0; n < 200 && !got; n++) begin
      step(1'b0, 1'b0);
      if (rdy_seen[c]) begin got = 1'b1; lat = cyc - start; end
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [RSZ-1:0] rd_of(input int c);
    return rd_data_M[RSZ*c +: RSZ];
  endfunction

  initial begin
    int lat, i3, i1b, n1;
    reset = 1'b1; enable_M = '0; addr_M = '0; wr_data_M = '0;
    for (int i = 0; i < N; i++) begin
      rq_en[i] = 2'b00; rq_addr[i] = '0; rq_wd[i] = '0;
      rq_sticky[i] = 1'b0; rdy_seen[i] = 1'b0; age[i] = 0;
      rd_m[i] = '0; rd_known[i] = 1'b0;
    end
    for (int k = 0; k < 8; k++) pool[k] = ASZ'(k * 3 + (CLR ? 0 : 'h200));

    do_reset();
    idle(1);
    chk("rst_ready", 32'(ready_M), 32'd0);
    chk("rst_rd", 32'(rd_data_M), 32'd0);

`ifndef SHMEM_CLEAR_ON_RESET_EN
    // write then read, single core
    do_reset();
    xact(0, 2'b10, 12'h012, 8'hA5, lat);
    chk("wr_lat", 32'(lat), 32'd2);
    xact(0, 2'b01, 12'h012, 8'h00, lat);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_a5", 32'(rd_of(0)), 32'hA5);

    // all four read at once straight out of reset
    do_reset();
    done_core.delete(); done_cyc.delete();
    for (int i = 0; i < N; i++) begin rq_en[i] = 2'b01; rq_addr[i] = 12'h012; end
    n1 = cyc + 1;
    idle(14);
    chk("simul_count", 32'(done_core.size()), 32'd4);
    if (done_core.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("simul_order", 32'(done_core[i]), 32'(i));
        chk("simul_when", 32'(done_cyc[i] - n1), 32'(2 + 3 * i));
      end

    // fairness: core 1 continuous, core 3 arrives after core 1's first grant
    done_core.delete(); done_cyc.delete();
    rq_sticky[1] = 1'b1; rq_en[1] = 2'b01; rq_addr[1] = 12'h012;
    for (int n = 0; n < 20 && done_core.size() == 0; n++) idle(1);
    rq_en[3] = 2'b01; rq_addr[3] = 12'h012; rdy_seen[3] = 1'b0;
    idle(12);
    rq_sticky[1] = 1'b0;
    idle(8);
    i3 = -1; i1b = -1; n1 = 0;
    foreach (done_core[k]) begin
      if (done_core[k] == 3 && i3 < 0) i3 = k;
      if (done_core[k] == 1) begin n1++; if (n1 == 2) i1b = k; end
    end
    chk("fair_seen", 32'(i3 >= 0 && i1b >= 0), 32'd1);
    chk("fair_order", 32'(i3 < i1b), 32'd1);

    // illegal 2'b11 is a read and must not write
    xact(2, 2'b10, 12'h020, 8'h33, lat);
    xact(2, 2'b11, 12'h020, 8'hFF, lat);
    chk("ill_rd", 32'(rd_of(2)), 32'h33);
    xact(0, 2'b01, 12'h020, 8'h00, lat);
    chk("ill_mem", 32'(rd_of(0)), 32'h33);

    // reset in WAIT aborts the write and its ready
    rq_en[0] = 2'b10; rq_addr[0] = 12'h100; rq_wd[0] = 8'h77; rdy_seen[0] = 1'b0;
    step(1'b0, 1'b0);
    rq_en[0] = 2'b00;
    step(1'b1, 1'b0);
    done_core.delete(); done_cyc.delete();
    idle(4);
    chk("rstw_noready", 32'(done_core.size()), 32'd0);
    xact(0, 2'b01, 12'h100, 8'h00, lat);
    chk("rstw_nocommit", 32'(rd_of(0) == 8'h77), 32'd0);

    // requester drops enable during WAIT; write still lands
    rq_en[1] = 2'b10; rq_addr[1] = 12'h030; rq_wd[1] = 8'h5C; rdy_seen[1] = 1'b0;
    step(1'b0, 1'b0);
    rq_en[1] = 2'b00;
    done_core.delete(); done_cyc.delete();
    idle(3);
    chk("drop_done", 32'(done_core.size()), 32'd1);
    xact(2, 2'b01, 12'h030, 8'h00, lat);
    chk("drop_wr", 32'(rd_of(2)), 32'h5C);
`else
    // clear after reset holds a waiting request off for DEPTH cycles
    do_reset();
    xact(0, 2'b01, 5'h05, 4'h0, lat);
    chk("clr_lat", 32'(lat), 32'(DEPTH + L));
    chk("clr_rd", 32'(rd_of(0)), 32'h0);
    xact(1, 2'b10, 5'h05, 4'h9, lat);
    xact(1, 2'b01, 5'h05, 4'h0, lat);
    chk("clr_wr", 32'(rd_of(1)), 32'h9);
    // reset midway through clear restarts it
    do_reset();
    idle(10);
    step(1'b1, 1'b0);
    xact(2, 2'b01, 5'h05, 4'h0, lat);
    chk("clr_restart_lat", 32'(lat), 32'(DEPTH + L));
    chk("clr_zero", 32'(rd_of(2)), 32'h0);
`endif

    // random traffic against the model
    for (int k = 0; k < 8; k++) xact(k % N, 2'b10, pool[k], RSZ'($urandom), lat);
    for (int n = 0; n < 3000; n++) step(n == 1500, 1'b1);
    for (int n = 0; n < 200; n++) begin
      if (!tx_v && rq_en[0] == 2'b00 && rq_en[1] == 2'b00 &&
          rq_en[2] == 2'b00 && rq_en[3] == 2'b00) break;
      step(1'b0, 1'b0);
    end
    chk("drain", 32'(tx_v), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_mem_responder.md
Name: shared_mem_responder

Overview:
- Responder end of the core memory port (enable_M / addr_M / wr_data_M -> rd_data_M / ready_M).
- Serves CORE_COUNT cores from one shared data memory, which every core reaches through LD/ST.
- Arbitrates pending requests round-robin and services one request at a time with a fixed access latency.
- Returns ready_M for exactly one cycle per completed transaction, in the same cycle as the read data.

Parameters:
CORE_COUNT, 4, number of requesting cores / memory ports
REG_SIZE, 8, data width; also the width of the low address field
CORE_ID_SIZE, 4, width of the high address field; ADDR_SIZE = CORE_ID_SIZE + REG_SIZE
ACCESS_LATENCY, 2, cycles from grant to response; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable_M  in  2*CORE_COUNT  per-core request; core i uses bits [2i+1:2i]; 2'b00 idle, 2'b01 read, 2'b10 write
addr_M  in  ADDR_SIZE*CORE_COUNT  per-core address {core_id field, reg field}
wr_data_M  in  REG_SIZE*CORE_COUNT  per-core write data
rd_data_M  out  REG_SIZE*CORE_COUNT  per-core read data, registered
ready_M  out  CORE_COUNT  per-core completion pulse

Behaviour:
- Memory: 2^ADDR_SIZE words of REG_SIZE bits, indexed by the full addr_M. No wrap or truncation.
- A requester holds enable, addr and wr_data stable until it sees ready_M high. It may change them the cycle after.
- Reset values: ready_M = 0, rd_data_M = 0, state = IDLE, round-robin pointer = 0, internal latched request cleared.
- FSM states: IDLE, WAIT, RESP (plus CLEAR with the optional feature).
- IDLE:
  - If any enable is nonzero, grant the first requester at or after the pointer, in modular order.
  - Latch the grantee's index, op, addr and wr_data.
  - Set the pointer to (grant+1) mod CORE_COUNT.
  - Load the latency counter with ACCESS_LATENCY-1. Go to WAIT, or straight to RESP if ACCESS_LATENCY = 1.
  - If no enable is nonzero, stay in IDLE with the pointer unchanged.
- WAIT: decrement the counter each cycle; on reaching 0, go to RESP.
- RESP (one cycle):
  - ready_M[grant] = 1.
  - Read: rd_data_M[grant] presents mem[addr] in this cycle.
  - Write: mem[addr] <= wr_data at the end of this cycle; rd_data_M[grant] is unchanged.
  - Next state is always IDLE. A repeated or new request from the same core is therefore arbitrated afresh, so no double service occurs.
- Net latency: the request is seen in IDLE at cycle t; ready_M pulses at cycle t+ACCESS_LATENCY.
- rd_data_M[i] holds its last value between responses; other cores' rd_data_M do not change.
- ready_M is one-hot or zero; it is never high outside RESP.
- enable 2'b11 is illegal and is serviced as a read, with no memory write.
- Requester drops enable during WAIT: the latched transaction still completes (a write still commits) and the ready pulse is still issued.
- Reset mid-transaction: the transaction is aborted, no write commits, no ready is issued, and the FSM returns to IDLE.
- Requests that arrive while the FSM is in WAIT or RESP are not lost; they stay pending because requesters hold them.
- Starvation bound: a request waits at most CORE_COUNT*(ACCESS_LATENCY+1) cycles before grant.

Optional Feature:
SHMEM_CLEAR_ON_RESET_EN
- Defined:
  - Reset enters CLEAR; an address counter starts at 0.
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - After address 2^ADDR_SIZE-1 is written, the next cycle is IDLE. Clear takes 2^ADDR_SIZE cycles.
  - Requests are ignored and ready_M stays 0 during CLEAR.
  - Reset asserted during CLEAR restarts the clear from address 0.
- Undefined: memory contents are not initialised and the FSM enters IDLE directly on reset.

Decomposition:
- Shared define header (alongside the core include set) holds:
  - the enable encodings ENABLE_SIZE=2, ENABLE_READ=2'b01, ENABLE_WRITE=2'b10;
  - the REG, ADDR and CORE_ID sizes and ranges;
  - the FSM state encodings.
- One sub-module: rr_arbiter, a CORE_COUNT-wide request vector plus pointer to a one-hot grant and grant index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Write then read, single core: core 0 writes 0xA5 to addr 0x012; ready_M[0] at t+2. Core 0 then reads 0x012 -> rd_data_M[0]=0xA5 with ready_M[0] in the same cycle, exactly 2 cycles after the request is seen.
- Simultaneous requests: all 4 cores read in the same cycle from reset. Grants in order 0,1,2,3; ready pulses at cycles 2, 5, 8, 11 relative to first IDLE; ready_M is never multi-hot.
- Fairness: core 1 requests continuously; core 3 requests once after core 1's first grant. Core 3 is granted before core 1's second grant.
- Illegal op: core 2 issues enable=2'b11 at addr 0x020 holding 0x33, with wr_data 0xFF. rd_data_M[2]=0x33 and mem[0x020] is still 0x33.
- Reset in WAIT: core 0 writes 0x77 to 0x100; reset is asserted in the WAIT cycle. No ready pulse; a later read of 0x100 does not return 0x77 (0x00 with SHMEM_CLEAR_ON_RESET_EN).
- Feature on, with CORE_ID_SIZE=1, REG_SIZE=4: ready_M stays 0 for 32 cycles after reset even though a request is held. After that, the read returns 0x0 at cycle 32+2.
